// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: ALU, data memory and the registered write-back packet.
// Optional MEM_WB_SAT_EN makes ADD/SUB saturate instead of wrapping.
module mem_wb_stage #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [2:0] gp_rdata1_address_in,
    input  logic [2:0] gp_rdata2_address_in,
    input  logic [9:0] aluA_in,
    input  logic [9:0] aluB_in,
    input  logic [2:0] alu_ctrl_in,
    input  logic       gp_reg_wb_in,
    output logic       stall,
    output logic       wb_valid,
    output logic       wb_en,
    output logic [2:0] wb_addr,
    output logic [2:0] wb_src2,
    output logic [9:0] wb_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CW-1:0] CntInit = (LOAD_LAT >= 2) ? CW'(LOAD_LAT - 2) : '0;

    localparam logic [2:0] OpAdd   = 3'b000;
    localparam logic [2:0] OpSub   = 3'b001;
    localparam logic [2:0] OpAnd   = 3'b010;
    localparam logic [2:0] OpOr    = 3'b011;
    localparam logic [2:0] OpXor   = 3'b100;
    localparam logic [2:0] OpSltu  = 3'b101;
    localparam logic [2:0] OpLoad  = 3'b110;
    localparam logic [2:0] OpStore = 3'b111;

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   ld_addr_q;
    logic [2:0]      ld_rd_q;
    logic [2:0]      ld_src2_q;
    logic            ld_wb_q;
    logic            wb_valid_q;
    logic            wb_en_q;
    logic [2:0]      wb_addr_q;
    logic [2:0]      wb_src2_q;
    logic [9:0]      wb_data_q;

    logic [9:0]      mem [DEPTH];

    logic [9:0]      sum;
    logic [9:0]      diff;
    logic            borrow;
    logic [9:0]      alu_res;
    logic [AW-1:0]   ld_addr;
    logic [AW-1:0]   st_addr;
    logic            is_load;
    logic            accept;

`ifdef MEM_WB_SAT_EN
    logic            carry;
    assign {carry, sum} = {1'b0, aluA_in} + {1'b0, aluB_in};
`else
    assign sum = aluA_in + aluB_in;
`endif
    assign diff    = aluA_in - aluB_in;
    assign borrow  = aluA_in < aluB_in;
    assign ld_addr = sum[AW-1:0];
    assign st_addr = aluA_in[AW-1:0];
    assign is_load = alu_ctrl_in == OpLoad;
    assign accept  = (state_q == StIdle) && valid_in;

    always_comb begin
        alu_res = '0;
        unique case (alu_ctrl_in)
            OpAdd: begin
                alu_res = sum;
`ifdef MEM_WB_SAT_EN
                if (carry) alu_res = 10'd1023;
`endif
            end
            OpSub: begin
                alu_res = diff;
`ifdef MEM_WB_SAT_EN
                if (borrow) alu_res = 10'd0;
`endif
            end
            OpAnd:   alu_res = aluA_in & aluB_in;
            OpOr:    alu_res = aluA_in | aluB_in;
            OpXor:   alu_res = aluA_in ^ aluB_in;
            OpSltu:  alu_res = {9'd0, borrow};
            OpLoad:  alu_res = '0;
            OpStore: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // Memory is deliberately not reset; the write commits at the accepting edge.
    always_ff @(posedge clk) begin
        if (reset && accept && alu_ctrl_in == OpStore) begin
            mem[st_addr] <= aluB_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ld_addr_q  <= '0;
            ld_rd_q    <= '0;
            ld_src2_q  <= '0;
            ld_wb_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_src2_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        if (is_load && LOAD_LAT > 1) begin
                            ld_addr_q <= ld_addr;
                            ld_rd_q   <= gp_rdata1_address_in;
                            ld_src2_q <= gp_rdata2_address_in;
                            ld_wb_q   <= gp_reg_wb_in;
                            cnt_q     <= CntInit;
                            state_q   <= StLoadWait;
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_en_q    <= gp_reg_wb_in & (alu_ctrl_in != OpStore);
                            wb_addr_q  <= gp_rdata1_address_in;
                            wb_src2_q  <= gp_rdata2_address_in;
                            wb_data_q  <= is_load ? mem[ld_addr] : alu_res;
                        end
                    end
                end
                StLoadWait: begin
                    // Upstream is holding the same packet, so valid_in is ignored here.
                    if (cnt_q == '0) begin
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= ld_wb_q;
                        wb_addr_q  <= ld_rd_q;
                        wb_src2_q  <= ld_src2_q;
                        wb_data_q  <= mem[ld_addr_q];
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall    = state_q == StLoadWait;
    assign wb_valid = wb_valid_q;
    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_src2  = wb_src2_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised self-checking bench for mem_wb_stage against an arithmetic reference model.
module tb_mem_wb_stage;

    localparam int DEPTH    = 16;
    localparam int LOAD_LAT = 2;
`ifdef MEM_WB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [2:0] rd_in;
    logic [2:0] rs2_in;
    logic [9:0] a_in;
    logic [9:0] b_in;
    logic [2:0] op_in;
    logic       wb_in;
    logic       stall;
    logic       wb_valid;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [2:0] wb_src2;
    logic [9:0] wb_data;

    int errors = 0;
    int checks = 0;
    int model_mem [DEPTH];

    mem_wb_stage #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .valid_in             (valid_in),
        .gp_rdata1_address_in (rd_in),
        .gp_rdata2_address_in (rs2_in),
        .aluA_in              (a_in),
        .aluB_in              (b_in),
        .alu_ctrl_in          (op_in),
        .gp_reg_wb_in         (wb_in),
        .stall                (stall),
        .wb_valid             (wb_valid),
        .wb_en                (wb_en),
        .wb_addr              (wb_addr),
        .wb_src2              (wb_src2),
        .wb_data              (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected packet {valid, en, addr, src2, data, stall_after, wait_ok}; updates model memory.
    task automatic model_pkt(input int op, input int a, input int b, input int rd, input int rs2,
                             input bit wb, output logic [19:0] exp);
        int res;
        bit en;
        res = 0;
        en  = wb;
        case (op)
            0: begin
                res = a + b;
                if (res > 1023) res = SAT ? 1023 : res - 1024;
            end
            1: begin
                if (a >= b) res = a - b;
                else        res = SAT ? 0 : a - b + 1024;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (a < b) ? 1 : 0;
            6: res = model_mem[((a + b) % 1024) % DEPTH];
            default: begin
                model_mem[a % DEPTH] = b;
                res = 0;
                en  = 1'b0;
            end
        endcase
        exp = {1'b1, en, 3'(rd), 3'(rs2), 10'(res), 1'b0, 1'b1};
    endtask

    // Present one packet, hold it through any load wait, and capture the resulting packet.
    task automatic send(input int op, input int a, input int b, input int rd, input int rs2,
                        input bit wb, output logic [19:0] obs);
        bit wait_ok;
        valid_in = 1'b1;
        op_in    = 3'(op);
        a_in     = 10'(a);
        b_in     = 10'(b);
        rd_in    = 3'(rd);
        rs2_in   = 3'(rs2);
        wb_in    = wb;
        wait_ok  = 1'b1;
        @(posedge clk);
        #1;
        if (op == 6 && LOAD_LAT > 1) begin
            for (int k = 0; k < LOAD_LAT - 1; k++) begin
                if (!(stall === 1'b1 && wb_valid === 1'b0)) wait_ok = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        obs = {wb_valid, wb_en, wb_addr, wb_src2, wb_data, stall, wait_ok};
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        op_in    = '0;
        a_in     = '0;
        b_in     = '0;
        rd_in    = '0;
        rs2_in   = '0;
        wb_in    = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({stall, wb_valid, wb_en, wb_addr, wb_src2, wb_data} !== 19'd0) begin
            errors++;
            $display("FAIL reset_async: got %b expected all zero",
                     {stall, wb_valid, wb_en, wb_addr, wb_src2, wb_data});
        end
        valid_in = 1'b1;
        op_in    = 3'd0;
        a_in     = 10'd7;
        b_in     = 10'd9;
        wb_in    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({stall, wb_valid, wb_en, wb_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_held: got %b expected all zero", {stall, wb_valid, wb_en, wb_data});
        end
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_alu_directed();
        logic [19:0] obs, exp;
        int a [3] = '{1000, 5, 5};
        int b [3] = '{100, 9, 9};
        int op [3] = '{0, 1, 5};
        int want [3];
        want[0] = SAT ? 1023 : 76;
        want[1] = SAT ? 0 : 1020;
        want[2] = 1;
        for (int i = 0; i < 3; i++) begin
            model_pkt(op[i], a[i], b[i], 5, 2, 1'b1, exp);
            send(op[i], a[i], b[i], 5, 2, 1'b1, obs);
            checks++;
            if (obs !== exp || obs[11:2] !== 10'(want[i])) begin
                errors++;
                $display("FAIL alu_directed[%0d]: got %h expected %h (data %0d)", i, obs, exp, want[i]);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_store_load();
        logic [19:0] obs, exp;
        model_pkt(7, 3, 10'h2AA, 6, 1, 1'b1, exp);
        send(7, 3, 10'h2AA, 6, 1, 1'b1, obs);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL store_pkt: got %h expected %h", obs, exp);
        end
        model_pkt(6, 1, 2, 4, 3, 1'b1, exp);
        send(6, 1, 2, 4, 3, 1'b1, obs);
        checks++;
        if (obs !== exp || obs[11:2] !== 10'h2AA) begin
            errors++;
            $display("FAIL store_then_load: got %h expected %h", obs, exp);
        end
        valid_in = 1'b0;
    endtask

    task automatic test_idle();
        logic [19:0] obs, exp;
        model_pkt(4, 10'h155, 10'h0F0, 3, 7, 1'b1, exp);
        send(4, 10'h155, 10'h0F0, 3, 7, 1'b1, obs);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({wb_valid, wb_en, wb_addr, wb_data} !== {2'b00, exp[17:15], exp[11:2]}) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h",
                     {wb_valid, wb_en, wb_addr, wb_data}, {2'b00, exp[17:15], exp[11:2]});
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] obs [4];
        logic [19:0] exp [4];
        for (int i = 0; i < 4; i++) begin
            model_pkt(i, 100 * (i + 1), 37 + i, i + 1, 7 - i, 1'b1, exp[i]);
            send(i, 100 * (i + 1), 37 + i, i + 1, 7 - i, 1'b1, obs[i]);
        end
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] obs, exp;
        int op, a, b;
        for (int i = 0; i < DEPTH; i++) begin
            model_pkt(7, i, $urandom_range(0, 1023), 0, 0, 1'b1, exp);
            send(7, i, exp[11:2], 0, 0, 1'b1, obs);
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        for (int i = 0; i < DEPTH; i++) begin
            b = $urandom_range(0, 1023);
            model_pkt(7, i + DEPTH * $urandom_range(0, 3), b, 1, 1, 1'b1, exp);
            send(7, i + DEPTH * $urandom_range(0, 3), b, 1, 1, 1'b1, obs);
        end
        // The two passes above may address differently; rebuild the model from a clean pass.
        for (int i = 0; i < DEPTH; i++) begin
            b = $urandom_range(0, 1023);
            model_mem[i] = b;
            send(7, i, b, 0, 0, 1'b0, obs);
        end
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 1023);
            b  = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) == 0) begin
                a = 1023 - $urandom_range(0, 3);
                b = $urandom_range(0, 1) ? a : 1023;
            end
            model_pkt(op, a, b, $urandom_range(0, 7), n % 8, 1'($urandom_range(0, 1)), exp);
            send(op, a, b, exp[17:15], exp[14:12], exp[18] | (op == 7 ? 1'b1 : 1'b0), obs);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%0d b=%0d: got %h expected %h",
                         n, op, a, b, obs, exp);
            end
            if ($urandom_range(0, 4) == 0) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
                checks++;
                if ({wb_valid, wb_en, stall} !== 3'b000) begin
                    errors++;
                    $display("FAIL random_gap[%0d]: got %b expected 000", n, {wb_valid, wb_en, stall});
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [19:0] obs, exp;
        valid_in = 1'b1;
        op_in    = 3'd6;
        a_in     = 10'd2;
        b_in     = 10'd3;
        rd_in    = 3'd6;
        rs2_in   = 3'd5;
        wb_in    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stall !== (LOAD_LAT > 1)) begin
            errors++;
            $display("FAIL load_stall_entry: got %b expected %b", stall, LOAD_LAT > 1);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({stall, wb_valid, wb_en, wb_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_load: got %b expected all zero", {stall, wb_valid, wb_en, wb_data});
        end
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_pkt(0, 300, 200, 2, 4, 1'b1, exp);
        send(0, 300, 200, 2, 4, 1'b1, obs);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL after_reset_first: got %h expected %h", obs, exp);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        test_reset();
        test_alu_directed();
        test_store_load();
        test_idle();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
